// File: rtl/adder_str_full_adder.sv
// Single-bit full adder: the leaf cell of the ripple-carry chain.
// Purely combinational; carry-out uses the generate/propagate form.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum bit and carry-out from generate (a&b) or propagated carry-in.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_str.sv
// Structural N-bit ripple-carry adder with a registered copy of the result.
// The combinational sum is a chain of full_adder cells, so no '+' is used
// in the datapath. The output register is cleared asynchronously by rst_n.
module adder_str #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic [N-1:0] s_q,
  output logic         cout_q
);

  // carry[i] is the carry into bit i; carry[N] leaves the top of the chain.
  logic [N:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[N];

  // One full adder per bit, each feeding its carry to the next bit up.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      full_adder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .s    (s[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Capture the settled sum each rising edge; reset clears at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_adder_str.sv
// Self-checking bench for adder_str (N=5). The reference is plain integer
// arithmetic: expected {cout,s} = a + b + cin, and the registered outputs
// follow the previous cycle's expected value or zero under reset.
module tb_adder_str;

  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
  logic [N-1:0] s_q;
  logic         cout_q;

  int checks;
  int errors;

  // Expected registered value (what s_q/cout_q should currently hold).
  int exp_q;

  adder_str #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .s_q    (s_q),
    .cout_q (cout_q)
  );

  // 10 ns clock: rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Apply one vector between edges, check the combinational result and
  // that the register has not moved yet, then check it after the edge.
  task automatic txn(input string tag, input int av, input int bv, input int cv);
    int total;
    @(negedge clk);
    a   = av[N-1:0];
    b   = bv[N-1:0];
    cin = cv[0];
    total = av + bv + cv;
    #1;
    $display("txn %s a=%0d b=%0d cin=%0d s=%0d cout=%0d", tag, av, bv, cv, s, cout);
    check({tag, "_s"},    {27'd0, s},        total % (1 << N));
    check({tag, "_cout"}, {31'd0, cout},     total >> N);
    check({tag, "_hold"}, {26'd0, cout_q, s_q}, exp_q);
    @(posedge clk);
    #1;
    exp_q = total;
    check({tag, "_sq"},   {27'd0, s_q},      exp_q % (1 << N));
    check({tag, "_coq"},  {31'd0, cout_q},   exp_q >> N);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_q  = 0;
    rst_n  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;

    // Reset state.
    #1;
    check("rst_sq",   {27'd0, s_q},    0);
    check("rst_coq",  {31'd0, cout_q}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    txn("zero",     0,  0,  0);
    txn("ident",    0,  0,  1);
    txn("max",     31, 31,  1);
    txn("ripple",  31,  0,  1);
    txn("msbcarry",16, 16,  0);
    txn("latency",  7,  9,  0);

    // Async reset between edges: registers clear, comb path keeps 16.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q = 0;
    check("arst_sq",  {27'd0, s_q},    0);
    check("arst_coq", {31'd0, cout_q}, 0);
    check("arst_s",   {27'd0, s},      16);
    @(posedge clk);
    #1;
    check("arst_held", {26'd0, cout_q, s_q}, 0);

    // Release with 20+15+1 = 36: s_q=4, cout_q=1 only after the next edge.
    @(negedge clk);
    a = 5'd20; b = 5'd15; cin = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rel_pre", {26'd0, cout_q, s_q}, 0);
    @(posedge clk);
    #1;
    exp_q = 36;
    check("rel_sq",  {27'd0, s_q},    4);
    check("rel_coq", {31'd0, cout_q}, 1);
    $display("txn release a=20 b=15 cin=1 s_q=%0d cout_q=%0d", s_q, cout_q);

    // Exhaustive sweep of every input combination.
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 32; x++)
        for (int y = 0; y < 32; y++)
          txn("sweep", x, y, c);

    // Randomized vectors.
    for (int i = 0; i < 200; i++)
      txn("rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
